// File: rtl/fifo_arb_pkg.sv
// Shared types for the FIFO write arbiter.
// Build option: FIFO_ARB_PRIORITY_EN makes requester 0 strict-priority.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic int id_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Requester handshakes and FIFO write port of the arbiter.
// The arbiter takes the slave view; producers/FIFO take the master view.
interface fifo_write_arbiter_if #(
  parameter int n_req      = 4,
  parameter int data_width = 8,
  parameter int fifo_depth = 16
);
  localparam int cw = $clog2(fifo_depth) + 1;

  logic [n_req-1:0]            req_valid;
  logic [n_req*data_width-1:0] req_data;
  logic [n_req-1:0]            req_ready;
  logic                        fifo_write;
  logic [data_width-1:0]       fifo_data_in;
  logic [cw-1:0]               fifo_count;

  modport master (
    output req_valid, req_data, fifo_count,
    input  req_ready, fifo_write, fifo_data_in
  );

  modport slave (
    input  req_valid, req_data, fifo_count,
    output req_ready, fifo_write, fifo_data_in
  );
endinterface

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Rotating priority encoder: first request at or after start.
// FIFO_ARB_PRIORITY_EN lets requester 0 win whenever it is valid.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter  int n_req = 4,
  localparam int iw    = id_w(n_req)
) (
  input  logic [n_req-1:0] req,
  input  logic [iw-1:0]    start,
  input  logic [n_req-1:0] exclude,
  output logic             found,
  output logic [iw-1:0]    idx
);

  logic [n_req-1:0] cand;
  logic [iw-1:0]    pos;

  always_comb begin
    cand = req & ~exclude;
    // excluded requester is still eligible if nobody else asks
    if (cand == '0)
      cand = req;
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int k = n_req - 1; k >= 0; k--) begin
      pos = iw'((int'(start) + k) % n_req);
      if (cand[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
`ifdef FIFO_ARB_PRIORITY_EN
    if (req[0]) begin
      found = 1'b1;
      idx   = '0;
    end
`else
`endif
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter for one FIFO write port.
// Build option: FIFO_ARB_PRIORITY_EN (strict priority for requester 0).
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int n_req      = 4,
  parameter  int data_width = 8,
  parameter  int fifo_depth = 16,
  parameter  int max_burst  = 4,
  localparam int iw         = id_w(n_req)
) (
  input  logic                  clk,
  input  logic                  reset,
  fifo_write_arbiter_if.slave   bus,
  output logic [iw-1:0]         grant_id,
  output logic                  busy
);

  localparam int cw = $clog2(fifo_depth) + 1;
  localparam int sw = cw + 1;
  localparam int bw = $clog2(max_burst + 1);

  state_t           state, state_n;
  logic [iw-1:0]    grant_n, last, last_n;
  logic [bw-1:0]    burst_cnt, burst_n;
  logic [sw-1:0]    level;
  logic             space, xfer, rel, cur_valid;
  logic [n_req-1:0] gmask, excl;
  logic [iw-1:0]    start;
  logic             found;
  logic [iw-1:0]    idx;
  logic [data_width-1:0] cur_data;

  function automatic logic [iw-1:0] inc(input logic [iw-1:0] x);
    return (x == iw'(n_req - 1)) ? '0 : x + 1'b1;
  endfunction

  // the registered write is not yet in count, so include it
  assign level = {1'b0, bus.fifo_count} + sw'(bus.fifo_write);
  assign space = level < sw'(fifo_depth);

  assign gmask     = n_req'(1) << grant_id;
  assign cur_valid = bus.req_valid[grant_id];
  assign cur_data  = bus.req_data[int'(grant_id)*data_width +: data_width];
  assign xfer      = (state == GRANT) && cur_valid && space;
  assign busy      = (state == GRANT);

  assign bus.req_ready = (state == GRANT && space) ? gmask : '0;

  assign rel = (state == GRANT) &&
    (!cur_valid ||
     (xfer && ({1'b0, burst_cnt} + 1'b1 == (bw+1)'(max_burst))));

  rr_pick #(.n_req(n_req)) u_pick (
    .req     (bus.req_valid),
    .start   (start),
    .exclude (excl),
    .found   (found),
    .idx     (idx)
  );

  always_comb begin
    state_n = state;
    grant_n = grant_id;
    last_n  = last;
    burst_n = burst_cnt;
    start   = inc(last);
    excl    = '0;
    unique case (1'b1)
      state == IDLE: begin
        if (found) begin
          state_n = GRANT;
          grant_n = idx;
          burst_n = '0;
        end
      end
      default: begin
        start = inc(grant_id);
        excl  = gmask;
        if (xfer)
          burst_n = burst_cnt + 1'b1;
        if (rel) begin
          last_n = grant_id;
          if (found) begin
            grant_n = idx;
            burst_n = '0;
          end else begin
            state_n = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      grant_id         <= '0;
      last             <= iw'(n_req - 1);
      burst_cnt        <= '0;
      bus.fifo_write   <= 1'b0;
      bus.fifo_data_in <= '0;
    end else begin
      state          <= state_n;
      grant_id       <= grant_n;
      last           <= last_n;
      burst_cnt      <= burst_n;
      bus.fifo_write <= xfer;
      if (xfer)
        bus.fifo_data_in <= cur_data;
    end
  end

endmodule
